crypto_dispatch: RTL and testbench
==================================

# crypto_dispatch

Command scheduler between the general-purpose CPU and the three crypto engines (hash H, encrypt E, decrypt D). It accepts CPU commands into an in-order queue and issues each one as a one-cycle start pulse with a memory index to the target engine once that engine is idle. It tracks which engines are busy and turns each engine's done pulse into a sticky interrupt (H_int/E_int/D_int) that stays high until the CPU clears it.

## Interface
Parameters:
- IDX_W, 16, width of the memory index passed to the engines.
- DEPTH, 4, command queue depth; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  CPU presents a command.
- cmd_ready  out  1  queue can accept; high exactly when count < DEPTH.
- cmd_op  in  2  0=hash, 1=encrypt, 2=decrypt, 3=illegal.
- cmd_index  in  IDX_W  memory index for the command.
- H_start, E_start, D_start  out  1 each  registered one-cycle start pulse.
- eng_index  out  IDX_W  registered index; valid in the cycle its start pulse is high.
- H_done, E_done, D_done  in  1 each  one-cycle completion pulse from each engine.
- H_int, E_int, D_int  out  1 each  sticky completion interrupts.
- int_clr  in  3  per-engine interrupt clear; bit0=H, bit1=E, bit2=D.
- busy  out  3  per-engine busy flags, same bit order as int_clr.
- q_count  out  $clog2(DEPTH)+1  number of queued commands.
- err  out  1  sticky error flag. Set by an illegal op or a done pulse from an idle engine. Cleared only by rst.

## Operation
- Enqueue: the command {op, index} is written at the tail on any edge where cmd_valid && cmd_ready.
  - op=3 is consumed (handshake completes) but not queued, and it sets err.
- Dispatch is in order, with head-of-line blocking.
  - On each edge, if q_count>0 and busy[head.op]==0, the head is popped.
  - The matching start output and eng_index are registered high/valid for exactly one cycle.
  - busy[head.op] is set on the same edge.
  - Later commands never bypass a blocked head.
- Completion: a done pulse sampled while busy[x]==1 clears busy[x] and sets int[x] on the same edge.
  - A done pulse while busy[x]==0 is ignored, and it sets err.
- Interrupt clear: int_clr[x] clears int[x].
  - If done[x] and int_clr[x] occur on the same edge, the set wins and int[x] stays 1.
- Queue pointers wrap modulo DEPTH.
  - Simultaneous enqueue and dispatch leaves q_count unchanged.
  - Dispatch from a full queue raises cmd_ready on the next cycle.
- Reset values: cmd_ready=1, all starts=0, eng_index=0, ints=0, busy=0, q_count=0, err=0, pointers=0.
- Reset mid-operation discards queued commands and busy state.
  - An engine's done arriving after reset therefore sets err. Software must reset the engines together with this block.

## Timing
- Enqueue at edge k: start pulse is high in the cycle after edge k+1. Minimum latency is 1 cycle from acceptance to start.
- busy[x] is high in the cycle after edge k+1, together with the start pulse.
- done[x] sampled at edge j: int[x]=1 and busy[x]=0 after edge j. A queued command for x can start after edge j+1, since dispatch uses registered busy.
- Back-to-back commands to different idle engines dispatch on consecutive edges, one per edge. At most one start is high per cycle.
- cmd_ready and q_count are registered and reflect state after the previous edge. There is no combinational path from cmd_valid to cmd_ready.

## Test plan
- Reset, then cmd {op=0, index=0x0040} at edge 3.
  - Required: H_start=1 and eng_index=0x0040 for exactly one cycle after edge 4; busy=3'b001.
  - Then H_done at edge 10. Required: busy=0 and H_int=1 after edge 10; int_clr=3'b001 at edge 12 drops H_int.
- Head-of-line blocking: E is busy; queue {E,0x10}, {D,0x20}.
  - Required: D_start stays low until E_done.
  - E_done at edge j. Required: E_start (index 0x10) after edge j+1, D_start (index 0x20) after edge j+2.
- Fill the queue: with H busy, push DEPTH hash commands.
  - Required: q_count=4, cmd_ready=0, a 5th cmd_valid is not accepted.
  - H_done. Required: one dispatch, q_count=3, cmd_ready=1.
  - Push more commands to exercise pointer wrap. Required: the original index order is preserved.
- Same-edge H_done and int_clr[0] with H_int already 1. Required: H_int remains 1.
  - An illegal op=3 command. Required: accepted, q_count unchanged, err=1.
- Assert rst for 1 cycle while D is busy with 2 commands queued.
  - Required: all outputs return to reset values.
  - A subsequent D_done. Required: err=1 and no D_int.

Source files
------------

// File: rtl/crypto_dispatch.sv
// Command scheduler for the hash/encrypt/decrypt engines. It keeps an in-order command queue,
// dispatches each command as a start pulse, tracks busy engines, and raises sticky interrupts.
module crypto_dispatch #(
    parameter int unsigned IDX_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [IDX_W-1:0]           cmd_index,
    output logic                       H_start,
    output logic                       E_start,
    output logic                       D_start,
    output logic [IDX_W-1:0]           eng_index,
    input  logic                       H_done,
    input  logic                       E_done,
    input  logic                       D_done,
    output logic                       H_int,
    output logic                       E_int,
    output logic                       D_int,
    input  logic [2:0]                 int_clr,
    output logic [2:0]                 busy,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [1:0]       op_q  [DEPTH];
    logic [IDX_W-1:0] idx_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       busy_q, busy_d, int_q, int_d, start_q, start_d;
    logic [IDX_W-1:0] eng_index_q, eng_index_d;
    logic             err_q, err_d;

    logic       accept, illegal, push, pop;
    logic [1:0] head_op;
    logic [2:0] head_sel, done;

    assign done      = {D_done, E_done, H_done};
    assign cmd_ready = (count_q != CW'(DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign illegal   = accept && (cmd_op == 2'd3);
    assign push      = accept && (cmd_op != 2'd3);
    assign head_op   = op_q[rd_ptr_q];

    always_comb begin
        head_sel = 3'b000;
        unique case (head_op)
            2'd0:    head_sel = 3'b001;
            2'd1:    head_sel = 3'b010;
            2'd2:    head_sel = 3'b100;
            default: head_sel = 3'b000;
        endcase
    end

    // Registered busy gates dispatch, so a freed engine is reused one edge after its done.
    assign pop = (count_q != '0) && (head_sel != 3'b000) && ((busy_q & head_sel) == 3'b000);

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        busy_d      = (busy_q & ~done) | (pop ? head_sel : 3'b000);
        // A done pulse beats a same-edge clear.
        int_d       = (int_q & ~int_clr) | (done & busy_q);
        err_d       = err_q | illegal | (|(done & ~busy_q));
        start_d     = pop ? head_sel : 3'b000;
        eng_index_d = pop ? idx_q[rd_ptr_q] : eng_index_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            int_q       <= '0;
            err_q       <= 1'b0;
            start_q     <= '0;
            eng_index_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            int_q       <= int_d;
            err_q       <= err_d;
            start_q     <= start_d;
            eng_index_q <= eng_index_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_q[wr_ptr_q]  <= cmd_op;
            idx_q[wr_ptr_q] <= cmd_index;
        end
    end

    assign H_start   = start_q[0];
    assign E_start   = start_q[1];
    assign D_start   = start_q[2];
    assign eng_index = eng_index_q;
    assign H_int     = int_q[0];
    assign E_int     = int_q[1];
    assign D_int     = int_q[2];
    assign busy      = busy_q;
    assign q_count   = count_q;
    assign err       = err_q;
endmodule

// File: tb/tb_crypto_dispatch.sv
// Bench for crypto_dispatch: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_crypto_dispatch;
    localparam int IDX_W = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_index = 16'h0;
    logic        H_start, E_start, D_start, H_int, E_int, D_int, err, cmd_ready;
    logic [15:0] eng_index;
    logic        H_done = 1'b0, E_done = 1'b0, D_done = 1'b0;
    logic [2:0]  int_clr = 3'b000;
    logic [2:0]  busy;
    logic [2:0]  q_count;

    int n_chk = 0;
    int n_err = 0;

    crypto_dispatch #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .H_start(H_start), .E_start(E_start), .D_start(D_start),
        .eng_index(eng_index), .H_done(H_done), .E_done(E_done), .D_done(D_done),
        .H_int(H_int), .E_int(E_int), .D_int(D_int), .int_clr(int_clr), .busy(busy),
        .q_count(q_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] idx;
    } cmd_t;

    cmd_t        m_q[$];
    logic [2:0]  m_busy = '0, m_int = '0, m_start = '0, m_done, m_b0;
    logic [15:0] m_idx = '0;
    logic        m_err = 1'b0, m_on = 1'b0;
    int          m_sz0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pre-edge state decides dispatch, completion and enqueue.
    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1;
            m_q.delete();
            m_busy = '0; m_int = '0; m_err = 1'b0; m_start = '0; m_idx = '0;
        end else if (m_on) begin
            m_done  = {D_done, E_done, H_done};
            m_b0    = m_busy;
            m_sz0   = m_q.size();
            m_start = '0;
            if (m_sz0 > 0 && !m_b0[m_q[0].op]) begin
                m_start[m_q[0].op] = 1'b1;
                m_busy[m_q[0].op]  = 1'b1;
                m_idx = m_q[0].idx;
                void'(m_q.pop_front());
            end
            m_busy = m_busy & ~(m_done & m_b0);
            m_int  = (m_int & ~int_clr) | (m_done & m_b0);
            if ((m_done & ~m_b0) != 3'b000) m_err = 1'b1;
            if (cmd_valid && m_sz0 < DEPTH) begin
                if (cmd_op == 2'd3) m_err = 1'b1;
                else m_q.push_back('{op: cmd_op, idx: cmd_index});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_on) begin
            check("cmp_start", 32'({D_start, E_start, H_start}), 32'(m_start));
            if (m_start != 3'b000) check("cmp_index", 32'(eng_index), 32'(m_idx));
            check("cmp_busy", 32'(busy), 32'(m_busy));
            check("cmp_int", 32'({D_int, E_int, H_int}), 32'(m_int));
            check("cmp_count", 32'(q_count), 32'(m_q.size()));
            check("cmp_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
            check("cmp_err", 32'(err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] idx);
        cmd_valid = 1'b1; cmd_op = op; cmd_index = idx;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 1);
        check({tag, "_count"}, 32'(q_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ints"}, 32'({D_int, E_int, H_int}), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_starts"}, 32'({D_start, E_start, H_start}), 0);
        check({tag, "_index"}, 32'(eng_index), 0);
    endtask

    initial begin
        logic [15:0] exp_idx;
        logic [2:0]  d;
        int          r;

        rst = 1'b1;
        cyc(); cyc();
        check_reset("rst1");
        rst = 1'b0;

        // Single hash command, completion and interrupt clear
        push(2'd0, 16'h0040);
        check("t1_count", 32'(q_count), 1);
        check("t1_nostart", 32'(H_start), 0);
        cyc();
        check("t1_hstart", 32'(H_start), 1);
        check("t1_index", 32'(eng_index), 32'h40);
        check("t1_busy", 32'(busy), 32'b001);
        cyc();
        check("t1_pulse_end", 32'(H_start), 0);
        repeat (3) cyc();
        H_done = 1'b1; cyc(); H_done = 1'b0;
        check("t1_busy_clr", 32'(busy), 0);
        check("t1_hint", 32'(H_int), 1);
        cyc();
        int_clr = 3'b001; cyc(); int_clr = 3'b000;
        check("t1_hint_clr", 32'(H_int), 0);

        // Head-of-line blocking
        push(2'd1, 16'h0001);
        push(2'd1, 16'h0010);
        push(2'd2, 16'h0020);
        check("t2_count", 32'(q_count), 2);
        repeat (3) begin
            cyc();
            check("t2_d_blocked", 32'(D_start), 0);
        end
        E_done = 1'b1; cyc(); E_done = 1'b0;
        check("t2_ebusy_clr", 32'(busy[1]), 0);
        check("t2_d_still_blocked", 32'(D_start), 0);
        cyc();
        check("t2_estart", 32'(E_start), 1);
        check("t2_eidx", 32'(eng_index), 32'h10);
        cyc();
        check("t2_dstart", 32'(D_start), 1);
        check("t2_didx", 32'(eng_index), 32'h20);
        E_done = 1'b1; D_done = 1'b1; cyc(); E_done = 1'b0; D_done = 1'b0;
        int_clr = 3'b111; cyc(); int_clr = 3'b000;
        check("t2_idle", 32'({busy, D_int, E_int, H_int}), 0);

        // Fill the queue, refuse overflow, then wrap the pointers
        push(2'd0, 16'h00A0);
        for (int i = 0; i < 4; i++) push(2'd0, 16'h00B0 + 16'(i));
        check("t3_full_count", 32'(q_count), 4);
        check("t3_full_ready", 32'(cmd_ready), 0);
        push(2'd0, 16'h00FF);
        check("t3_overflow", 32'(q_count), 4);
        H_done = 1'b1; cyc(); H_done = 1'b0;
        check("t3_after_done", 32'(q_count), 4);
        cyc();
        check("t3_pop_start", 32'(H_start), 1);
        check("t3_pop_idx", 32'(eng_index), 32'hB0);
        check("t3_pop_count", 32'(q_count), 3);
        check("t3_pop_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 11; i++) begin
            H_done = 1'b1;
            if (i < 8) begin
                cmd_valid = 1'b1; cmd_op = 2'd0; cmd_index = 16'h00C0 + 16'(i);
            end
            cyc();
            H_done = 1'b0; cmd_valid = 1'b0;
            cyc();
            exp_idx = (i < 3) ? 16'h00B1 + 16'(i) : 16'h00C0 + 16'(i - 3);
            check("t3_wrap_order", 32'(H_start ? eng_index : 16'hDEAD), 32'(exp_idx));
        end

        // Done and clear on the same edge: set wins
        check("t4_hint_pre", 32'(H_int), 1);
        H_done = 1'b1; int_clr = 3'b001; cyc(); H_done = 1'b0; int_clr = 3'b000;
        check("t4_hint_kept", 32'(H_int), 1);

        // Illegal op with commands queued behind a busy decrypt engine
        push(2'd2, 16'h0030);
        push(2'd2, 16'h0031);
        push(2'd2, 16'h0032);
        check("t5_count", 32'(q_count), 2);
        check("t5_ready", 32'(cmd_ready), 1);
        push(2'd3, 16'h0099);
        check("t5_illegal_count", 32'(q_count), 2);
        check("t5_err", 32'(err), 1);

        // Reset mid-operation, then a stale done
        rst = 1'b1; cyc(); rst = 1'b0;
        check_reset("rst2");
        D_done = 1'b1; cyc(); D_done = 1'b0;
        check("t6_err", 32'(err), 1);
        check("t6_no_dint", 32'(D_int), 0);
        check("t6_busy", 32'(busy), 0);

        // Randomized traffic
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            r         = int'($urandom_range(63));
            cmd_valid = ($urandom_range(1) == 1);
            cmd_op    = (r == 0) ? 2'd3 : 2'(r % 3);
            cmd_index = 16'($urandom);
            for (int x = 0; x < 3; x++) begin
                d[x] = (m_busy[x] && $urandom_range(3) == 0) || ($urandom_range(299) == 0);
                int_clr[x] = ($urandom_range(7) == 0);
            end
            {D_done, E_done, H_done} = d;
            rst = ($urandom_range(399) == 0);
            cyc();
        end
        rst = 1'b0; cmd_valid = 1'b0; {D_done, E_done, H_done} = 3'b000; int_clr = 3'b000;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
